cheri_tsmap_arbiter: RTL and testbench

//  Shares the single-port temporal-safety (TS) map SRAM between two requesters: the core's

---
 rtl/cheri_pkg.sv | 19 +
 rtl/cheri_tsmap_arbiter_chk.sv | 25 ++
 rtl/cheri_tsmap_arbiter.sv | 132 +++++++++++++
 tb/tb_cheri_tsmap_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_pkg.sv
// Shared types and helpers for the CHERI temporal-safety map logic.
// Owner encoding tags which requester the in-flight SRAM response belongs to.
package cheri_pkg;

  localparam int unsigned TSMapAddrW = 16;

  typedef enum logic [1:0] {
    TSARB_NONE = 2'd0,
    TSARB_CORE = 2'd1,
    TSARB_BG   = 2'd2
  } tsarb_owner_e;

  // Word addresses at or beyond the map size have no backing SRAM word
  function automatic logic tsmap_addr_oob(input logic [TSMapAddrW-1:0] addr,
                                          input int unsigned           size);
    return ({16'h0000, addr} >= size);
  endfunction

endpackage

// File: rtl/cheri_tsmap_arbiter_chk.sv
// Protocol checker for the TS map arbiter, observed purely at its ports.
// Kept apart from the design so the datapath stays free of assertions.
module cheri_tsmap_arbiter_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic core_gnt,
  input logic bg_gnt,
  input logic core_rvalid,
  input logic bg_rvalid,
  input logic tsmap_cs
);

  a_gnt_mutex: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(core_gnt && bg_gnt));

  a_core_rvalid_after_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core_rvalid |-> $past(core_gnt));

  a_bg_rvalid_after_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bg_rvalid |-> $past(bg_gnt));

  a_cs_needs_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tsmap_cs |-> (core_gnt || bg_gnt));

endmodule

// File: rtl/cheri_tsmap_arbiter.sv
// Shares the single-port TS map SRAM between the core lookup port and the revocation sweeper.
// Core has fixed priority; a starvation counter lets the sweeper win after StarveLimit lost conflicts.
module cheri_tsmap_arbiter
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize   = 1024,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic [TSMapAddrW-1:0] core_addr_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  input  logic                  bg_req_i,
  input  logic [TSMapAddrW-1:0] bg_addr_i,
  output logic                  bg_gnt_o,
  output logic                  bg_rvalid_o,
  output logic [31:0]           bg_rdata_o,
  output logic                  bg_err_o,
  output logic                  tsmap_cs_o,
  output logic [TSMapAddrW-1:0] tsmap_addr_o,
  input  logic [31:0]           tsmap_rdata_i
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  tsarb_owner_e          owner_q, owner_d;
  logic                  err_q, err_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  conflict_s, core_win_s, bg_win_s, any_win_s;
  logic [TSMapAddrW-1:0] win_addr_s;

  // Arbitration; grants are held off while reset is asserted so all outputs read 0
  always_comb begin
    core_win_s = 1'b0;
    bg_win_s   = 1'b0;
    conflict_s = core_req_i & bg_req_i;
    if (!rst_ni) begin
      core_win_s = 1'b0;
      bg_win_s   = 1'b0;
    end else if (conflict_s) begin
      if (starve_cnt_q == StarveMax) begin
        bg_win_s = 1'b1;
      end else begin
        core_win_s = 1'b1;
      end
    end else if (core_req_i) begin
      core_win_s = 1'b1;
    end else if (bg_req_i) begin
      bg_win_s = 1'b1;
    end else begin
      core_win_s = 1'b0;
      bg_win_s   = 1'b0;
    end
  end

  assign any_win_s  = core_win_s | bg_win_s;
  assign win_addr_s = bg_win_s ? bg_addr_i : core_addr_i;
  assign err_d      = any_win_s & tsmap_addr_oob(win_addr_s, TSMapSize);

  assign core_gnt_o   = core_win_s;
  assign bg_gnt_o     = bg_win_s;
  assign tsmap_cs_o   = any_win_s & ~err_d;
  assign tsmap_addr_o = tsmap_cs_o ? win_addr_s : 16'h0000;

  // Next owner of the one-deep response pipeline
  always_comb begin
    if (core_win_s) begin
      owner_d = TSARB_CORE;
    end else if (bg_win_s) begin
      owner_d = TSARB_BG;
    end else begin
      owner_d = TSARB_NONE;
    end
  end

  // Count conflicts the sweeper lost in a row; any break in that run restarts it
  always_comb begin
    if (conflict_s && core_win_s) begin
      if (starve_cnt_q == StarveMax) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end
  end

  // Response pipeline and starvation state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= TSARB_NONE;
      err_q        <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Route the SRAM word to whoever was granted last cycle; errored reads return 0
  always_comb begin
    core_rvalid_o = 1'b0;
    core_rdata_o  = 32'h0000_0000;
    core_err_o    = 1'b0;
    bg_rvalid_o   = 1'b0;
    bg_rdata_o    = 32'h0000_0000;
    bg_err_o      = 1'b0;
    case (owner_q)
      TSARB_CORE: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = err_q ? 32'h0000_0000 : tsmap_rdata_i;
        core_err_o    = err_q;
      end
      TSARB_BG: begin
        bg_rvalid_o = 1'b1;
        bg_rdata_o  = err_q ? 32'h0000_0000 : tsmap_rdata_i;
        bg_err_o    = err_q;
      end
      default: begin
        core_rvalid_o = 1'b0;
        bg_rvalid_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// Self-checking bench for cheri_tsmap_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a request-level model of the arbitration rules.
module tb_cheri_tsmap_arbiter;

  localparam int unsigned TS_SIZE = 1024;
  localparam int unsigned STARVE  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, bg_req_i;
  logic [15:0] core_addr_i, bg_addr_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic        bg_gnt_o, bg_rvalid_o, bg_err_o;
  logic [31:0] core_rdata_o, bg_rdata_o, tsmap_rdata_i;
  logic        tsmap_cs_o;
  logic [15:0] tsmap_addr_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  cheri_tsmap_arbiter #(.TSMapSize(TS_SIZE), .StarveLimit(STARVE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .bg_req_i(bg_req_i), .bg_addr_i(bg_addr_i), .bg_gnt_o(bg_gnt_o),
    .bg_rvalid_o(bg_rvalid_o), .bg_rdata_o(bg_rdata_o), .bg_err_o(bg_err_o),
    .tsmap_cs_o(tsmap_cs_o), .tsmap_addr_o(tsmap_addr_o), .tsmap_rdata_i(tsmap_rdata_i)
  );

  cheri_tsmap_arbiter_chk u_chk (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_gnt(core_gnt_o), .bg_gnt(bg_gnt_o),
    .core_rvalid(core_rvalid_o), .bg_rvalid(bg_rvalid_o), .tsmap_cs(tsmap_cs_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM contents as a pure function of address
  function automatic logic [31:0] sram_word(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {~a, a} ^ 32'h5A5A_1234;
  endfunction

  // SRAM model: data the cycle after a select, garbage otherwise
  always @(posedge clk_i) begin
    if (tsmap_cs_o) tsmap_rdata_i <= sram_word(tsmap_addr_o);
    else            tsmap_rdata_i <= $urandom();
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected grant from request rules, expected response one cycle later
  int          m_pend   = 0;   // 0 none, 1 core, 2 sweeper
  bit          m_err    = 1'b0;
  logic [31:0] m_rdata  = 32'h0;
  int          m_losses = 0;

  always @(negedge clk_i) begin
    logic        e_core, e_bg, e_err, e_cs;
    logic [15:0] e_addr;
    if (chk_en) begin
      if (!rst_ni) begin
        cmp("rst_ctrl", 64'({core_gnt_o, core_rvalid_o, core_err_o, bg_gnt_o,
                             bg_rvalid_o, bg_err_o, tsmap_cs_o}), 64'h0);
        cmp("rst_rdata", {core_rdata_o, bg_rdata_o}, 64'h0);
        cmp("rst_addr", 64'(tsmap_addr_o), 64'h0);
        m_pend   = 0;
        m_losses = 0;
      end else begin
        cmp("core_resp", 64'({core_rvalid_o, core_err_o, core_rdata_o}),
            64'({m_pend == 1, (m_pend == 1) && m_err, (m_pend == 1) ? m_rdata : 32'h0}));
        cmp("bg_resp", 64'({bg_rvalid_o, bg_err_o, bg_rdata_o}),
            64'({m_pend == 2, (m_pend == 2) && m_err, (m_pend == 2) ? m_rdata : 32'h0}));
        e_core = core_req_i && (!bg_req_i || (m_losses < int'(STARVE)));
        e_bg   = bg_req_i && !e_core;
        e_addr = e_bg ? bg_addr_i : core_addr_i;
        e_err  = (e_core || e_bg) && (int'(e_addr) >= int'(TS_SIZE));
        e_cs   = (e_core || e_bg) && !e_err;
        cmp("grant", 64'({core_gnt_o, bg_gnt_o, tsmap_cs_o, tsmap_addr_o}),
            64'({e_core, e_bg, e_cs, e_cs ? e_addr : 16'h0}));
        m_pend   = e_core ? 1 : (e_bg ? 2 : 0);
        m_err    = e_err;
        m_rdata  = e_err ? 32'h0 : sram_word(e_addr);
        m_losses = (e_core && bg_req_i) ? m_losses + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic cr, input logic [15:0] ca, input logic br, input logic [15:0] ba);
    core_req_i  = cr;
    core_addr_i = ca;
    bg_req_i    = br;
    bg_addr_i   = ba;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'h0400;
      1:       return 16'h03FF;
      2:       return 16'($urandom_range(1025, 65535));
      default: return 16'($urandom_range(0, 1022));
    endcase
  endfunction

  // Both requesters held high; the sweeper should win when (i % period) == period-1
  task automatic conflict_run(input int n, input int period);
    logic [1:0] exp_g;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 16'($urandom_range(0, 1023)), 1'b1, 16'($urandom_range(0, 1023)));
      @(negedge clk_i);
      exp_g = ((period != 0) && ((i % period) == period - 1)) ? 2'b01 : 2'b10;
      cmp("conflict_gnt", 64'({core_gnt_o, bg_gnt_o}), 64'(exp_g));
      tick();
    end
  endtask

  initial begin
    logic g_c, g_b;
    rst_ni = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single core read
    drive(1'b1, 16'h0010, 1'b0, 16'h0);
    @(negedge clk_i);
    cmp("t1_gnt", 64'({core_gnt_o, bg_gnt_o, tsmap_cs_o, tsmap_addr_o}), 64'({3'b101, 16'h0010}));
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk_i);
    cmp("t1_resp", 64'({core_rvalid_o, core_err_o, core_rdata_o}), 64'({2'b10, 32'hDEADBEEF}));
    cmp("t1_bg_quiet", 64'({bg_rvalid_o, bg_err_o, bg_rdata_o}), 64'h0);
    tick();

    // Sustained conflict: 4:1 pattern
    conflict_run(10, 5);

    // Sweeper out of range
    drive(1'b0, 16'h0, 1'b1, 16'h0400);
    @(negedge clk_i);
    cmp("t3_gnt", 64'({bg_gnt_o, tsmap_cs_o, tsmap_addr_o}), 64'({2'b10, 16'h0000}));
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk_i);
    cmp("t3_resp", 64'({bg_rvalid_o, bg_err_o, bg_rdata_o}), 64'({2'b11, 32'h0}));
    tick();

    // Back-to-back core then sweeper
    drive(1'b1, 16'h0123, 1'b0, 16'h0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 16'h0234);
    @(negedge clk_i);
    cmp("t4_core", 64'({core_rvalid_o, core_rdata_o}), 64'({1'b1, sram_word(16'h0123)}));
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk_i);
    cmp("t4_bg", 64'({core_rvalid_o, bg_rvalid_o, bg_rdata_o}), 64'({2'b01, sram_word(16'h0234)}));
    tick();

    // Reset right after a grant drops the response and the starvation count
    conflict_run(2, 0);
    drive(1'b1, 16'h0020, 1'b0, 16'h0);
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    cmp("t5_in_rst", 64'({core_gnt_o, core_rvalid_o, tsmap_cs_o}), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      cmp("t5_no_rvalid", 64'({core_rvalid_o, bg_rvalid_o}), 64'h0);
      tick();
    end
    conflict_run(5, 5);

    // Sweeper withdraws mid-run: counter restarts
    conflict_run(3, 0);
    drive(1'b1, 16'h0042, 1'b0, 16'h0);
    tick();
    conflict_run(5, 5);

    // Random traffic; a pending request stays up until granted, its address may wander
    g_c = 1'b1;
    g_b = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!(core_req_i && !g_c)) core_req_i = ($urandom_range(0, 2) != 0);
      if (!(bg_req_i && !g_b))   bg_req_i   = ($urandom_range(0, 2) != 0);
      core_addr_i = rand_addr();
      bg_addr_i   = rand_addr();
      if ($urandom_range(0, 199) == 0) rst_ni = 1'b0;
      else                             rst_ni = 1'b1;
      @(negedge clk_i);
      g_c = core_gnt_o;
      g_b = bg_gnt_o;
      tick();
    end

    rst_ni = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    repeat (2) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
